tow_match_scorer: RTL and testbench
===================================

Name: tow_match_scorer

Overview:
- Parametrised next-generation tug-of-war scorer.
- Tracks the rope position over a configurable number of steps per side, applies proper-push and jump-the-light rules with a selectable favour-the-loser rule and jump penalty, and counts game wins to a configurable match length.
- Sits after the push arbiter, which supplies winrnd/right/tie, and the light sequencer, which supplies leds_on; drives the LED bar.

Parameters:
- DEPTH, 3: positions per side before a win; legal range 1..7.
- FAVOUR_LOSER, 1: 1 = proper push by the trailing player while the opponent sits at the last position snaps the position back to 1 step.
- JUMP_PENALTY, 1: steps moved on a jump-the-light push; legal range 1..DEPTH.
- GAMES_TO_WIN, 2: game wins needed to take the match; legal range 1..7.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- winrnd  in  1  one-cycle pulse: a player pushed.
- right  in  1  1 = right player pushed first.
- tie  in  1  simultaneous push; round ignored.
- leds_on  in  1  lights were on at the push (proper push).
- new_game  in  1  one-cycle pulse: start the next game after a game win.
- score  out  2*DEPTH+1  LED bar; MSB = left end, LSB = right end.
- game_win_l  out  1  one-cycle pulse: left won a game.
- game_win_r  out  1  one-cycle pulse: right won a game.
- games_l  out  3  left game-win count.
- games_r  out  3  right game-win count.
- match_over  out  1  match decided.
- match_winner_right  out  1  valid when match_over: 1 = right won.

Interface:
- One clock, clk.
- Reset rst is synchronous and active-high.
- All outputs are registered or decoded from registers only; no input reaches an output combinationally.

Behaviour:
- State:
  - signed position pos, range -DEPTH..+DEPTH; negative = left, 0 = neutral.
  - phase in {PLAY, WIN_HOLD, MATCH_DONE}.
  - win_side.
  - games_l, games_r.
- Reset (rst=1 at a clk edge): pos=0, phase=PLAY, all counts 0, game_win_* 0, match_over 0, match_winner_right 0, score = centre bit only (bit DEPTH).
- Direction: mr = (right & leds_on) | (~right & ~leds_on). mr=1 moves toward right (+).
- An event occurs when winrnd & ~tie & phase==PLAY. No event means pos holds.
- Proper push (leds_on=1):
  - If FAVOUR_LOSER and pos==+DEPTH and mr=0: pos=+1.
  - If FAVOUR_LOSER and pos==-DEPTH and mr=1: pos=-1.
  - Otherwise pos moves 1 step toward mr.
- Jump push (leds_on=0): candidate = pos ± JUMP_PENALTY toward mr.
- Win rule: if the candidate magnitude exceeds DEPTH, that side wins the game. Then:
  - phase=WIN_HOLD next cycle; pos holds its last legal value.
  - game_win_l or game_win_r is high for exactly that one cycle.
  - The matching count increments on the same edge.
- If the incremented count == GAMES_TO_WIN: phase=MATCH_DONE instead of WIN_HOLD, match_over=1, match_winner_right set.
- Latency: score reflects an event on the clk edge after winrnd; one cycle.
- WIN_HOLD:
  - winrnd ignored.
  - new_game causes pos=0, phase=PLAY on the next edge.
  - winrnd and new_game together: new_game taken, winrnd dropped.
- MATCH_DONE: all inputs except rst ignored; outputs frozen.
- new_game in PLAY is ignored.
- Score decode:
  - PLAY: one-hot at bit index DEPTH-pos.
  - WIN_HOLD/MATCH_DONE, left win: top DEPTH bits set, rest 0.
  - WIN_HOLD/MATCH_DONE, right win: bottom DEPTH bits set, rest 0.
  - Illegal pos or phase: alternating pattern with bit 0 = 1; the next phase forces PLAY with pos=0.
- Reset mid-game or mid-match clears everything, including counts.

Decomposition:
- Shared package tow_pkg holds:
  - the phase enum;
  - score-pattern helper functions (win-left mask, win-right mask, error pattern), all sized by DEPTH.
- Sub-module tow_score_decode: pure decode of (phase, pos, win_side) to score, parametrised by DEPTH. This is the only natural split. The top module holds the state machine and counters.

Test Plan:
- Defaults, rst, then 4 proper right pushes:
  - score 0001000→0000100→0000010→0000001→0000111.
  - game_win_r high exactly 1 cycle; games_r=1.
- FAVOUR_LOSER=1, pos=+3, left proper push → score 0000100. Same stimulus with FAVOUR_LOSER=0 → 0000010.
- JUMP_PENALTY=2, at neutral, left push with leds_on=0 → 0000010. A second left jump → right game win, 0000111.
- winrnd with tie=1, and winrnd during WIN_HOLD → no score/count change. new_game with winrnd in WIN_HOLD → score 0001000, PLAY.
- GAMES_TO_WIN=2, two right game wins separated by new_game:
  - match_over=1, match_winner_right=1, games_r=2.
  - Further new_game/winrnd ignored.
  - rst → score 0001000, counts 0.
- DEPTH=1:
  - score width 3, reset 010.
  - A right proper push gives 001; the next gives 001 with game_win_r.
  - Left win shows 100.

Source files
------------

// File: rtl/tow_pkg.sv
// Shared types and LED-bar pattern helpers for the tug-of-war scorer.
// Patterns are built at the widest supported bar and trimmed by the user.
package tow_pkg;

  localparam int MAX_DEPTH = 7;
  localparam int MAX_W     = 2 * MAX_DEPTH + 1;

  typedef enum logic [1:0] {
    PLAY       = 2'd0,
    WIN_HOLD   = 2'd1,
    MATCH_DONE = 2'd2
  } phase_t;

  // Left end is the MSB, so a left win lights bits above the centre.
  function automatic logic [MAX_W-1:0] win_left_mask(input int depth);
    logic [MAX_W-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_W; i++) m[i] = (i > depth) && (i <= 2 * depth);
    return m;
  endfunction

  function automatic logic [MAX_W-1:0] win_right_mask(input int depth);
    logic [MAX_W-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_W; i++) m[i] = (i < depth);
    return m;
  endfunction

  function automatic logic [MAX_W-1:0] error_pattern(input int depth);
    logic [MAX_W-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_W; i++) m[i] = (i <= 2 * depth) && ((i % 2) == 0);
    return m;
  endfunction

endpackage

// File: rtl/tow_score_decode.sv
// Pure combinational decode of (phase, pos, win_side) onto the LED bar.
// Zero latency; no flow control, output follows the state registers.
module tow_score_decode
  import tow_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic [1:0]       phase,
  input  logic [3:0]       pos,
  input  logic             win_side,
  output logic [2*DEPTH:0] score
);

  localparam int W = 2 * DEPTH + 1;

  int p;

  always_comb begin
    score = W'(error_pattern(DEPTH));
    p     = int'($signed(pos));
    case (phase_t'(phase))
      PLAY: begin
        if (p >= -DEPTH && p <= DEPTH) begin
          for (int i = 0; i < W; i++) score[i] = (i == DEPTH - p);
        end
      end
      WIN_HOLD, MATCH_DONE: begin
        score = win_side ? W'(win_right_mask(DEPTH)) : W'(win_left_mask(DEPTH));
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/tow_match_scorer.sv
// Tug-of-war rope position, game and match scorer driving the LED bar.
// One-cycle latency from winrnd to score; no backpressure, pulses are taken as they come.
module tow_match_scorer
  import tow_pkg::*;
#(
  parameter int DEPTH        = 3,
  parameter int FAVOUR_LOSER = 1,
  parameter int JUMP_PENALTY = 1,
  parameter int GAMES_TO_WIN = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             winrnd,
  input  logic             right,
  input  logic             tie,
  input  logic             leds_on,
  input  logic             new_game,
  output logic [2*DEPTH:0] score,
  output logic             game_win_l,
  output logic             game_win_r,
  output logic [2:0]       games_l,
  output logic [2:0]       games_r,
  output logic             match_over,
  output logic             match_winner_right
);

  phase_t             phase, phase_nxt;
  logic signed [3:0]  pos, pos_nxt;
  logic               win_side, win_side_nxt;
  logic [2:0]         gl_nxt, gr_nxt;
  logic               gwl_nxt, gwr_nxt;
  logic               mr;
  logic               pos_bad;
  int                 cand;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase      <= PLAY;
      pos        <= '0;
      win_side   <= 1'b0;
      games_l    <= '0;
      games_r    <= '0;
      game_win_l <= 1'b0;
      game_win_r <= 1'b0;
    end else begin
      phase      <= phase_nxt;
      pos        <= pos_nxt;
      win_side   <= win_side_nxt;
      games_l    <= gl_nxt;
      games_r    <= gr_nxt;
      game_win_l <= gwl_nxt;
      game_win_r <= gwr_nxt;
    end
  end

  always_comb begin
    phase_nxt    = phase;
    pos_nxt      = pos;
    win_side_nxt = win_side;
    gl_nxt       = games_l;
    gr_nxt       = games_r;
    gwl_nxt      = 1'b0;
    gwr_nxt      = 1'b0;
    mr           = ~(right ^ leds_on);
    cand         = int'(pos);
    pos_bad      = (int'(pos) > DEPTH) || (int'(pos) < -DEPTH);
    case (phase)
      PLAY: begin
        if (pos_bad) begin
          pos_nxt = '0;
        end else if (winrnd && !tie) begin
          // A trailing player's proper push snaps a cornered rope back to one step.
          if (leds_on) begin
            if (FAVOUR_LOSER != 0 && int'(pos) == DEPTH && !mr)       cand = 1;
            else if (FAVOUR_LOSER != 0 && int'(pos) == -DEPTH && mr)  cand = -1;
            else                                                      cand = mr ? int'(pos) + 1 : int'(pos) - 1;
          end else begin
            cand = mr ? int'(pos) + JUMP_PENALTY : int'(pos) - JUMP_PENALTY;
          end
          if (cand > DEPTH) begin
            win_side_nxt = 1'b1;
            gwr_nxt      = 1'b1;
            gr_nxt       = games_r + 3'd1;
            phase_nxt    = (int'(gr_nxt) == GAMES_TO_WIN) ? MATCH_DONE : WIN_HOLD;
          end else if (cand < -DEPTH) begin
            win_side_nxt = 1'b0;
            gwl_nxt      = 1'b1;
            gl_nxt       = games_l + 3'd1;
            phase_nxt    = (int'(gl_nxt) == GAMES_TO_WIN) ? MATCH_DONE : WIN_HOLD;
          end else begin
            pos_nxt = 4'(cand);
          end
        end
      end
      WIN_HOLD: begin
        if (new_game) begin
          pos_nxt   = '0;
          phase_nxt = PLAY;
        end
      end
      MATCH_DONE: ;
      default: begin
        pos_nxt   = '0;
        phase_nxt = PLAY;
      end
    endcase
  end

  always_comb begin
    match_over         = (phase == MATCH_DONE);
    match_winner_right = (phase == MATCH_DONE) && win_side;
  end

  tow_score_decode #(.DEPTH(DEPTH)) u_decode (
    .phase    (phase),
    .pos      (pos),
    .win_side (win_side),
    .score    (score)
  );

endmodule

// File: tb/tb_tow_match_scorer.sv
// Three parameter sets driven by shared stimulus, each scored against a behavioural model.
module tb_tow_match_scorer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, winrnd, right, tie, leds_on, new_game;

  logic [6:0] score0, score1;
  logic [2:0] score2;
  logic       gwl0, gwr0, mo0, mwr0, gwl1, gwr1, mo1, mwr1, gwl2, gwr2, mo2, mwr2;
  logic [2:0] gl0, gr0, gl1, gr1, gl2, gr2;

  tow_match_scorer #(.DEPTH(3), .FAVOUR_LOSER(1), .JUMP_PENALTY(1), .GAMES_TO_WIN(2)) u0 (
    .clk(clk), .rst(rst), .winrnd(winrnd), .right(right), .tie(tie), .leds_on(leds_on),
    .new_game(new_game), .score(score0), .game_win_l(gwl0), .game_win_r(gwr0),
    .games_l(gl0), .games_r(gr0), .match_over(mo0), .match_winner_right(mwr0));

  tow_match_scorer #(.DEPTH(3), .FAVOUR_LOSER(0), .JUMP_PENALTY(2), .GAMES_TO_WIN(3)) u1 (
    .clk(clk), .rst(rst), .winrnd(winrnd), .right(right), .tie(tie), .leds_on(leds_on),
    .new_game(new_game), .score(score1), .game_win_l(gwl1), .game_win_r(gwr1),
    .games_l(gl1), .games_r(gr1), .match_over(mo1), .match_winner_right(mwr1));

  tow_match_scorer #(.DEPTH(1), .FAVOUR_LOSER(1), .JUMP_PENALTY(1), .GAMES_TO_WIN(2)) u2 (
    .clk(clk), .rst(rst), .winrnd(winrnd), .right(right), .tie(tie), .leds_on(leds_on),
    .new_game(new_game), .score(score2), .game_win_l(gwl2), .game_win_r(gwr2),
    .games_l(gl2), .games_r(gr2), .match_over(mo2), .match_winner_right(mwr2));

  typedef struct packed {
    logic [14:0] score;
    logic        gwl;
    logic        gwr;
    logic [2:0]  gl;
    logic [2:0]  gr;
    logic        mo;
    logic        mwr;
  } obs_t;

  obs_t q0[$], q1[$], q2[$];

  int cD [3] = '{3, 3, 1};
  int cFL[3] = '{1, 0, 1};
  int cJP[3] = '{1, 2, 1};
  int cG [3] = '{2, 3, 2};

  // Model state: phase 0 = playing, 1 = holding after a game win, 2 = match decided.
  int m_pos[3], m_ph[3], m_ws[3], m_gl[3], m_gr[3];

  int n_cmp = 0;
  int n_err = 0;

  task automatic model_step(input int k, input logic r, input logic w, input logic rt,
                            input logic t, input logic l, input logic ng, output obs_t e);
    int d, step, cand, bar;
    logic pl, pr;
    d  = cD[k];
    pl = 1'b0;
    pr = 1'b0;
    if (r) begin
      m_pos[k] = 0; m_ph[k] = 0; m_ws[k] = 0; m_gl[k] = 0; m_gr[k] = 0;
    end else if (m_ph[k] == 0) begin
      if (w && !t) begin
        step = (rt == l) ? 1 : -1;
        if (l) begin
          if (cFL[k] != 0 && m_pos[k] == d && step < 0)       cand = 1;
          else if (cFL[k] != 0 && m_pos[k] == -d && step > 0) cand = -1;
          else                                                 cand = m_pos[k] + step;
        end else begin
          cand = m_pos[k] + step * cJP[k];
        end
        if (cand > d) begin
          m_ws[k] = 1; m_gr[k]++; pr = 1'b1;
          m_ph[k] = (m_gr[k] == cG[k]) ? 2 : 1;
        end else if (cand < -d) begin
          m_ws[k] = 0; m_gl[k]++; pl = 1'b1;
          m_ph[k] = (m_gl[k] == cG[k]) ? 2 : 1;
        end else begin
          m_pos[k] = cand;
        end
      end
    end else if (m_ph[k] == 1) begin
      if (ng) begin
        m_pos[k] = 0; m_ph[k] = 0;
      end
    end
    if (m_ph[k] == 0)       bar = 1 << (d - m_pos[k]);
    else if (m_ws[k] == 1)  bar = (1 << d) - 1;
    else                    bar = ((1 << d) - 1) << (d + 1);
    e.score = 15'(bar);
    e.gwl   = pl;
    e.gwr   = pr;
    e.gl    = 3'(m_gl[k]);
    e.gr    = 3'(m_gr[k]);
    e.mo    = (m_ph[k] == 2);
    e.mwr   = (m_ph[k] == 2) && (m_ws[k] == 1);
  endtask

  task automatic cycle(input logic r, input logic w, input logic rt, input logic t,
                       input logic l, input logic ng);
    obs_t e;
    @(negedge clk);
    rst = r; winrnd = w; right = rt; tie = t; leds_on = l; new_game = ng;
    model_step(0, r, w, rt, t, l, ng, e); q0.push_back(e);
    model_step(1, r, w, rt, t, l, ng, e); q1.push_back(e);
    model_step(2, r, w, rt, t, l, ng, e); q2.push_back(e);
  endtask

  task automatic compare(input int k, input obs_t e, input obs_t a);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL cfg%0d_outputs t=%0t: got score=%b gw=%b%b games=%0d/%0d mo=%b mwr=%b, required score=%b gw=%b%b games=%0d/%0d mo=%b mwr=%b",
               k, $time, a.score, a.gwl, a.gwr, a.gl, a.gr, a.mo, a.mwr,
               e.score, e.gwl, e.gwr, e.gl, e.gr, e.mo, e.mwr);
    end
  endtask

  task automatic dchk(input string nm, input logic [15:0] got, input logic [15:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %b, required %b", nm, got, want);
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    obs_t e, a;
    #1;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      a = '{15'(score0), gwl0, gwr0, gl0, gr0, mo0, mwr0};
      compare(0, e, a);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      a = '{15'(score1), gwl1, gwr1, gl1, gr1, mo1, mwr1};
      compare(1, e, a);
    end
    if (q2.size() > 0) begin
      e = q2.pop_front();
      a = '{15'(score2), gwl2, gwr2, gl2, gr2, mo2, mwr2};
      compare(2, e, a);
    end
  end

  initial begin
    rst = 1'b1; winrnd = 1'b0; right = 1'b0; tie = 1'b0; leds_on = 1'b0; new_game = 1'b0;

    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0); settle();
    dchk("reset_score_d3", 16'(score0), 16'b0001000);
    dchk("reset_score_d1", 16'(score2), 16'b010);

    // Four proper right pushes.
    cycle(0, 1, 1, 0, 1, 0); settle();
    dchk("push1_score", 16'(score0), 16'b0000100);
    cycle(0, 1, 1, 0, 1, 0); settle();
    dchk("push2_score", 16'(score0), 16'b0000010);
    dchk("d1_win_score", 16'(score2), 16'b001);
    dchk("d1_win_pulse", 16'(gwr2), 16'd1);
    cycle(0, 1, 1, 0, 1, 0); settle();
    dchk("push3_score", 16'(score0), 16'b0000001);
    cycle(0, 1, 1, 0, 1, 0); settle();
    dchk("push4_score", 16'(score0), 16'b0000111);
    dchk("push4_pulse", 16'(gwr0), 16'd1);
    dchk("push4_games_r", 16'(gr0), 16'd1);
    cycle(0, 1, 0, 0, 1, 0); settle();
    dchk("hold_pulse_gone", 16'(gwr0), 16'd0);
    dchk("hold_ignores_push", 16'(score0), 16'b0000111);

    cycle(0, 1, 0, 0, 1, 1); settle();
    dchk("new_game_with_push", 16'(score0), 16'b0001000);
    cycle(0, 1, 1, 1, 1, 0); settle();
    dchk("tie_ignored", 16'(score0), 16'b0001000);

    // Favour-the-loser snap back versus plain single step.
    repeat (3) cycle(0, 1, 1, 0, 1, 0);
    cycle(0, 1, 0, 0, 1, 0); settle();
    dchk("favour_loser_on", 16'(score0), 16'b0000100);
    dchk("favour_loser_off", 16'(score1), 16'b0000010);

    // Jump penalty of two on a left jump, which moves the rope right.
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0); settle();
    dchk("jump2_score", 16'(score1), 16'b0000010);
    cycle(0, 1, 0, 0, 0, 0); settle();
    dchk("jump2_win", 16'(score1), 16'b0000111);
    dchk("jump2_pulse", 16'(gwr1), 16'd1);

    // Match to two right game wins.
    cycle(1, 0, 0, 0, 0, 0);
    repeat (4) cycle(0, 1, 1, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 1);
    repeat (4) cycle(0, 1, 1, 0, 1, 0);
    settle();
    dchk("match_over", 16'(mo0), 16'd1);
    dchk("match_winner", 16'(mwr0), 16'd1);
    dchk("match_games_r", 16'(gr0), 16'd2);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 1, 0, 0, 1, 0); settle();
    dchk("match_frozen", 16'(score0), 16'b0000111);
    cycle(1, 0, 0, 0, 0, 0); settle();
    dchk("match_reset_score", 16'(score0), 16'b0001000);
    dchk("match_reset_games", 16'(gr0), 16'd0);

    // Left win on the narrow bar.
    cycle(0, 1, 0, 0, 1, 0); settle();
    dchk("d1_left_step", 16'(score2), 16'b100);
    cycle(0, 1, 0, 0, 1, 0); settle();
    dchk("d1_left_win", 16'(score2), 16'b100);
    dchk("d1_left_pulse", 16'(gwl2), 16'd1);

    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 1) == 1), 1'($urandom),
            ($urandom_range(0, 9) == 0), 1'($urandom), ($urandom_range(0, 4) == 0));
    end
    cycle(0, 0, 0, 0, 0, 0);
    settle();
    @(posedge clk); #3;

    n_cmp++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", q0.size() + q1.size() + q2.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
